// File: rtl/rggen_counter_field.sv
// Multi-channel event counter bit field for rggen register blocks.
// Optional snapshot shadow register enabled by defining RGGEN_COUNTER_SNAPSHOT_EN.
module rggen_counter_field #(
  parameter int                           CHANNELS      = 1,
  parameter int                           WIDTH         = 16,
  parameter int                           STEP_WIDTH    = 4,
  parameter logic [CHANNELS*WIDTH-1:0]    INITIAL_VALUE = '0,
  parameter logic                         SATURATE      = 1'b1,
  parameter logic                         READ_CLEAR    = 1'b0,
  parameter logic                         SW_WRITABLE   = 1'b1
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
`ifdef RGGEN_COUNTER_SNAPSHOT_EN
  input  logic                             i_snapshot,
`endif
  input  logic                             i_sw_write_valid,
  input  logic                             i_sw_read_valid,
  input  logic [CHANNELS*WIDTH-1:0]        i_sw_mask,
  input  logic [CHANNELS*WIDTH-1:0]        i_sw_write_data,
  output logic [CHANNELS*WIDTH-1:0]        o_sw_read_data,
  input  logic [CHANNELS-1:0]              i_hw_clear,
  input  logic [CHANNELS*STEP_WIDTH-1:0]   i_hw_up_step,
  input  logic [CHANNELS*STEP_WIDTH-1:0]   i_hw_down_step,
  input  logic [CHANNELS*WIDTH-1:0]        i_threshold,
  output logic [CHANNELS*WIDTH-1:0]        o_value,
  output logic [CHANNELS-1:0]              o_overflow,
  output logic [CHANNELS-1:0]              o_threshold_hit
);

  // Two guard bits: one for carry past the maximum, one for the sign of an underflow.
  localparam int SUM_W = WIDTH + 2;
  localparam logic signed [SUM_W-1:0] MAX_S = {2'b00, {WIDTH{1'b1}}};

  logic [CHANNELS*WIDTH-1:0] value_q;
  logic [CHANNELS*WIDTH-1:0] value_d;
  logic [CHANNELS-1:0]       ovf_q;
  logic [CHANNELS-1:0]       ovf_d;
  logic [CHANNELS-1:0]       hit_q;
  logic [CHANNELS-1:0]       hit_d;
  logic [CHANNELS*WIDTH-1:0] rd_src;

  function automatic logic out_of_range(input logic signed [SUM_W-1:0] s);
    return (s < 0) || (s > MAX_S);
  endfunction

  function automatic logic [WIDTH-1:0] fit(input logic signed [SUM_W-1:0] s);
    logic [WIDTH-1:0] r;
    r = s[WIDTH-1:0];
    if (SATURATE) begin
      if (s < 0)          r = '0;
      else if (s > MAX_S) r = '1;
    end
    return r;
  endfunction

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [WIDTH-1:0]        cur;
    logic [WIDTH-1:0]        msk;
    logic [WIDTH-1:0]        wdat;
    logic [WIDTH-1:0]        thr;
    logic [WIDTH-1:0]        base;
    logic [WIDTH-1:0]        nxt;
    logic [STEP_WIDTH-1:0]   up;
    logic [STEP_WIDTH-1:0]   dn;
    logic signed [SUM_W-1:0] sum;
    logic                    sel;
    logic                    rc_hit;
    logic                    wr_hit;

    assign cur  = value_q[c*WIDTH +: WIDTH];
    assign msk  = i_sw_mask[c*WIDTH +: WIDTH];
    assign wdat = i_sw_write_data[c*WIDTH +: WIDTH];
    assign thr  = i_threshold[c*WIDTH +: WIDTH];
    assign up   = i_hw_up_step[c*STEP_WIDTH +: STEP_WIDTH];
    assign dn   = i_hw_down_step[c*STEP_WIDTH +: STEP_WIDTH];

    assign sel    = |msk;
    assign rc_hit = READ_CLEAR && i_sw_read_valid && sel;
    assign wr_hit = SW_WRITABLE && i_sw_write_valid && sel;

    always_comb begin
      base = cur;
      if (i_hw_clear[c])  base = '0;
      else if (rc_hit)    base = '0;
      else if (wr_hit)    base = (cur & ~msk) | (wdat & msk);
    end

    // Steps are applied on top of the chosen base so same-cycle events survive a clear or load.
    assign sum = $signed({2'b00, base})
               + $signed({{(SUM_W-STEP_WIDTH){1'b0}}, up})
               - $signed({{(SUM_W-STEP_WIDTH){1'b0}}, dn});
    assign nxt = fit(sum);

    assign value_d[c*WIDTH +: WIDTH] = nxt;
    assign ovf_d[c] = out_of_range(sum) ? 1'b1
                    : (i_hw_clear[c] || rc_hit || wr_hit) ? 1'b0
                    : ovf_q[c];
    assign hit_d[c] = (cur < thr) && (nxt >= thr);

    assign o_sw_read_data[c*WIDTH +: WIDTH] = sel ? rd_src[c*WIDTH +: WIDTH] : '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      value_q <= INITIAL_VALUE;
      ovf_q   <= '0;
      hit_q   <= '0;
    end else begin
      value_q <= value_d;
      ovf_q   <= ovf_d;
      hit_q   <= hit_d;
    end
  end

`ifdef RGGEN_COUNTER_SNAPSHOT_EN
  logic [CHANNELS*WIDTH-1:0] shadow_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)        shadow_q <= INITIAL_VALUE;
    else if (i_snapshot) shadow_q <= value_q;
  end

  assign rd_src = shadow_q;
`else
  assign rd_src = value_q;
`endif

  assign o_value         = value_q;
  assign o_overflow      = ovf_q;
  assign o_threshold_hit = hit_q;

endmodule

// File: tb/tb_rggen_counter_field.sv
// Bench for rggen_counter_field: a saturating instance and a wrapping read-clear instance
// share stimulus and are checked against an integer reference model.
module tb_rggen_counter_field;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sw_we, sw_re;
  logic [15:0] sw_mask, sw_wdata, thr;
  logic [1:0]  hw_clr;
  logic [7:0]  up, dn;
`ifdef RGGEN_COUNTER_SNAPSHOT_EN
  logic        snap;
`endif

  logic [15:0] rd_a, val_a, rd_b, val_b;
  logic [1:0]  ovf_a, hit_a, ovf_b, hit_b;

  int vectors = 0;
  int miscompares = 0;

  // model state: index [dut][channel]; dut 0 saturates, dut 1 wraps with read-clear
  int m_val[2][2], n_val[2][2];
  int m_ovf[2][2], n_ovf[2][2];
  int m_hit[2][2], n_hit[2][2];
  int m_sh[2][2],  n_sh[2][2];

  always #5 clk = ~clk;

  rggen_counter_field #(
    .CHANNELS(2), .WIDTH(8), .STEP_WIDTH(4), .INITIAL_VALUE(16'h0000),
    .SATURATE(1'b1), .READ_CLEAR(1'b0), .SW_WRITABLE(1'b1)
  ) dut_a (
    .i_clk(clk), .i_rst_n(rst_n),
`ifdef RGGEN_COUNTER_SNAPSHOT_EN
    .i_snapshot(snap),
`endif
    .i_sw_write_valid(sw_we), .i_sw_read_valid(sw_re),
    .i_sw_mask(sw_mask), .i_sw_write_data(sw_wdata), .o_sw_read_data(rd_a),
    .i_hw_clear(hw_clr), .i_hw_up_step(up), .i_hw_down_step(dn),
    .i_threshold(thr), .o_value(val_a), .o_overflow(ovf_a), .o_threshold_hit(hit_a)
  );

  rggen_counter_field #(
    .CHANNELS(2), .WIDTH(8), .STEP_WIDTH(4), .INITIAL_VALUE(16'h0000),
    .SATURATE(1'b0), .READ_CLEAR(1'b1), .SW_WRITABLE(1'b1)
  ) dut_b (
    .i_clk(clk), .i_rst_n(rst_n),
`ifdef RGGEN_COUNTER_SNAPSHOT_EN
    .i_snapshot(snap),
`endif
    .i_sw_write_valid(sw_we), .i_sw_read_valid(sw_re),
    .i_sw_mask(sw_mask), .i_sw_write_data(sw_wdata), .o_sw_read_data(rd_b),
    .i_hw_clear(hw_clr), .i_hw_up_step(up), .i_hw_down_step(dn),
    .i_threshold(thr), .o_value(val_b), .o_overflow(ovf_b), .o_threshold_hit(hit_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] pack(input int a0, input int a1);
    logic [7:0] b0, b1;
    b0 = 8'(a0);
    b1 = 8'(a1);
    return {b1, b0};
  endfunction

  function automatic logic [1:0] pack2(input int a0, input int a1);
    return {a1 != 0, a0 != 0};
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 2; c++) begin
        m_val[d][c] = 0; m_ovf[d][c] = 0; m_hit[d][c] = 0; m_sh[d][c] = 0;
      end
  endtask

  function automatic logic [15:0] exp_rd(input int d);
    int r[2];
    for (int c = 0; c < 2; c++) begin
      r[c] = 0;
      if (sw_mask[c*8 +: 8] != 8'h00) begin
`ifdef RGGEN_COUNTER_SNAPSHOT_EN
        r[c] = m_sh[d][c];
`else
        r[c] = m_val[d][c];
`endif
      end
    end
    return pack(r[0], r[1]);
  endfunction

  // Next state from the rules in plain integer arithmetic.
  task automatic model_next();
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 2; c++) begin
        int cur, msk, wd, th, base, nx;
        bit sel, clr, oor;
        cur  = m_val[d][c];
        msk  = int'(sw_mask[c*8 +: 8]);
        wd   = int'(sw_wdata[c*8 +: 8]);
        th   = int'(thr[c*8 +: 8]);
        sel  = (msk != 0);
        base = cur;
        clr  = 1'b0;
        if (hw_clr[c]) begin
          base = 0; clr = 1'b1;
        end else if (d == 1 && sw_re && sel) begin
          base = 0; clr = 1'b1;
        end else if (sw_we && sel) begin
          base = (cur & ~msk) | (wd & msk); clr = 1'b1;
        end
        if ((d == 1 && sw_re && sel) || (sw_we && sel)) clr = 1'b1;
        nx  = base + int'(up[c*4 +: 4]) - int'(dn[c*4 +: 4]);
        oor = (nx > 255) || (nx < 0);
        if (oor) nx = (d == 0) ? ((nx > 255) ? 255 : 0) : (nx & 255);
        n_val[d][c] = nx;
        n_ovf[d][c] = oor ? 1 : (clr ? 0 : m_ovf[d][c]);
        n_hit[d][c] = ((cur < th) && (nx >= th)) ? 1 : 0;
        n_sh[d][c]  = m_sh[d][c];
`ifdef RGGEN_COUNTER_SNAPSHOT_EN
        if (snap) n_sh[d][c] = cur;
`endif
      end
  endtask

  task automatic check_state();
    chk("value_a", 32'(val_a), 32'(pack(m_val[0][0], m_val[0][1])));
    chk("ovf_a",   32'(ovf_a), 32'(pack2(m_ovf[0][0], m_ovf[0][1])));
    chk("hit_a",   32'(hit_a), 32'(pack2(m_hit[0][0], m_hit[0][1])));
    chk("value_b", 32'(val_b), 32'(pack(m_val[1][0], m_val[1][1])));
    chk("ovf_b",   32'(ovf_b), 32'(pack2(m_ovf[1][0], m_ovf[1][1])));
    chk("hit_b",   32'(hit_b), 32'(pack2(m_hit[1][0], m_hit[1][1])));
  endtask

  // One clock: read data checked before the edge, registered state after it.
  task automatic cycle();
    #1;
    chk("rdata_a", 32'(rd_a), 32'(exp_rd(0)));
    chk("rdata_b", 32'(rd_b), 32'(exp_rd(1)));
    model_next();
    @(posedge clk);
    #1;
    m_val = n_val; m_ovf = n_ovf; m_hit = n_hit; m_sh = n_sh;
    check_state();
  endtask

  task automatic idle();
    sw_we = 0; sw_re = 0; sw_mask = '0; sw_wdata = '0;
    hw_clr = '0; up = '0; dn = '0;
`ifdef RGGEN_COUNTER_SNAPSHOT_EN
    snap = 0;
`endif
  endtask

  task automatic write_ch0(input logic [7:0] v);
    idle();
    sw_we = 1; sw_mask = 16'h00FF; sw_wdata = {8'h00, v};
    cycle();
    idle();
  endtask

  initial begin
    idle();
    thr   = 16'hFFFF;
    rst_n = 1'b0;
    model_reset();
    #12;
    chk("reset_value_a", 32'(val_a), 32'h0);
    chk("reset_ovf_a",   32'(ovf_a), 32'h0);
    check_state();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // saturation on ch0, ch1 untouched
    up = 8'h04;
    for (int i = 0; i < 70; i++) cycle();
    chk("sat_max_ch0",  32'(val_a[7:0]),  32'd255);
    chk("sat_ovf_ch0",  32'(ovf_a[0]),    32'd1);
    chk("sat_ch1_zero", 32'(val_a[15:8]), 32'd0);

    // wrap from 254 by 3, then software write clears the flag
    write_ch0(8'hFE);
    up = 8'h03;
    cycle();
    chk("wrap_value", 32'(val_b[7:0]), 32'd1);
    chk("wrap_ovf",   32'(ovf_b[0]),   32'd1);
    write_ch0(8'h10);
    chk("load_value",   32'(val_b[7:0]), 32'h10);
    chk("load_ovf_clr", 32'(ovf_b[0]),   32'd0);

    // read-clear returns pre-clear count, same-cycle step survives
    write_ch0(8'd37);
    sw_re = 1; sw_mask = 16'h00FF; up = 8'h02;
    #1;
    chk("rc_rdata", 32'(rd_b[7:0]), 32'd37);
    cycle();
    idle();
    chk("rc_next_b", 32'(val_b[7:0]), 32'd2);
    chk("rc_next_a", 32'(val_a[7:0]), 32'd39);

    // threshold crossing: once going up, none while above, again after dipping
    thr = 16'h0064;
    write_ch0(8'd98);
    up = 8'h05;
    cycle();
    chk("thr_pulse1", 32'(hit_a[0]), 32'd1);
    up = 8'h01;
    for (int i = 0; i < 3; i++) cycle();
    up = 8'h00; dn = 8'h04;
    for (int i = 0; i < 4; i++) cycle();
    dn = 8'h00; up = 8'h03;
    for (int i = 0; i < 5; i++) cycle();
    idle();
    thr = 16'hFFFF;

    // hw_clear beats a write; partial-mask merge
    hw_clr = 2'b01; sw_we = 1; sw_mask = 16'h00FF; sw_wdata = 16'h0055;
    cycle();
    idle();
    chk("clr_priority", 32'(val_a[7:0]), 32'd0);
    write_ch0(8'h33);
    sw_we = 1; sw_mask = 16'h000F; sw_wdata = 16'h00AA;
    cycle();
    idle();
    chk("partial_merge", 32'(val_a[7:0]), 32'h3A);

`ifdef RGGEN_COUNTER_SNAPSHOT_EN
    write_ch0(8'd12);
    snap = 1;
    cycle();
    idle();
    up = 8'h01;
    for (int i = 0; i < 8; i++) cycle();
    idle();
    sw_mask = 16'h00FF;
    #1;
    chk("snap_rdata", 32'(rd_a[7:0]), 32'd12);
    cycle();
    idle();
`endif

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [7:0] m0, m1;
      idle();
      sw_we = ($urandom_range(0, 7) == 0);
      sw_re = ($urandom_range(0, 7) == 0);
      m0 = ($urandom_range(0, 2) == 0) ? 8'h00 : ($urandom_range(0, 1) ? 8'hFF : 8'($urandom_range(0, 255)));
      m1 = ($urandom_range(0, 2) == 0) ? 8'h00 : ($urandom_range(0, 1) ? 8'hFF : 8'($urandom_range(0, 255)));
      sw_mask  = {m1, m0};
      sw_wdata = 16'($urandom);
      hw_clr   = {($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0)};
      up       = 8'($urandom);
      dn       = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
      thr      = 16'($urandom);
`ifdef RGGEN_COUNTER_SNAPSHOT_EN
      snap     = ($urandom_range(0, 7) == 0);
`endif
      cycle();
    end
    idle();

    // asynchronous reset mid-count
    up = 8'h11;
    for (int i = 0; i < 5; i++) cycle();
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("midreset_value_a", 32'(val_a), 32'h0);
    chk("midreset_value_b", 32'(val_b), 32'h0);
    check_state();
    idle();
    @(posedge clk); #1;
    check_state();
    rst_n = 1'b1;
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rggen_counter_field.md
Name: rggen_counter_field

Overview:
- Multi-channel hardware event-counter bit field for rggen register blocks.
- Each channel holds a WIDTH-bit counter with these features:
  - hardware up/down steps per cycle
  - saturate or wrap mode
  - software load by masked write
  - optional clear-on-read
  - sticky overflow flag
  - threshold-crossing pulse
- Instantiated inside a register in place of a plain bit field. Software side connects to the register's read/write strobes; hardware side connects to event sources.

Parameters:
- CHANNELS, 1, number of independent counters.
- WIDTH, 16, counter width per channel.
- STEP_WIDTH, 4, width of each per-cycle up/down step.
- INITIAL_VALUE, {CHANNELS*WIDTH{1'b0}}, per-channel reset values, packed with channel 0 at the LSBs.
- SATURATE, 1'b1: 1 = clamp at 0 and 2^WIDTH-1; 0 = modulo-2^WIDTH wrap.
- READ_CLEAR, 1'b0: 1 = software read clears the channels it selects.
- SW_WRITABLE, 1'b1: 0 = software writes are ignored.

Ports:
- i_clk  input  1  clock
- i_rst_n  input  1  asynchronous active-low reset
- i_sw_write_valid  input  1  software write strobe
- i_sw_read_valid  input  1  software read strobe
- i_sw_mask  input  CHANNELS*WIDTH  byte-enable-derived bit mask
- i_sw_write_data  input  CHANNELS*WIDTH  write data
- o_sw_read_data  output  CHANNELS*WIDTH  read data
- i_hw_clear  input  CHANNELS  synchronous clear per channel
- i_hw_up_step  input  CHANNELS*STEP_WIDTH  increment amount (0 = none)
- i_hw_down_step  input  CHANNELS*STEP_WIDTH  decrement amount (0 = none)
- i_threshold  input  CHANNELS*WIDTH  compare value per channel
- o_value  output  CHANNELS*WIDTH  live counter values
- o_overflow  output  CHANNELS  sticky overflow/underflow flag
- o_threshold_hit  output  CHANNELS  one-cycle crossing pulse

Behaviour:
- Reset (async, i_rst_n=0): counters = INITIAL_VALUE, o_overflow=0, o_threshold_hit=0; shadow (if built) = INITIAL_VALUE.
- Channel c is selected by software when its mask slice is nonzero.
- Delta per channel: signed (STEP_WIDTH+1)-bit value = up_step - down_step. Computed in WIDTH+2 bits, then range-checked.
- Base value, highest priority first:
  1. i_hw_clear[c] -> 0
  2. READ_CLEAR && i_sw_read_valid && selected -> 0
  3. SW_WRITABLE && i_sw_write_valid && selected -> masked merge: (cur & ~mask) | (wdata & mask)
  4. otherwise -> cur
- Next value = base + delta. Events arriving in the same cycle as a clear or load are never lost.
- Out of range (result > 2^WIDTH-1 or < 0):
  - SATURATE=1: clamp to max or 0.
  - SATURATE=0: keep the low WIDTH bits.
  - Either mode: o_overflow[c] is set on the next edge.
- o_overflow[c] clears on hw_clear, read-clear, or software write of channel c. A simultaneous new overflow wins: the flag stays 1.
- o_threshold_hit[c] is registered. It is 1 for exactly one cycle after an edge where cur < thr and next >= thr (unsigned). Otherwise 0.
- o_sw_read_data returns the pre-update value in the same cycle as i_sw_read_valid, so a read-clear returns the count before clearing. Unselected channels read 0.
- Latency: a hardware step is visible on o_value 1 cycle later. Software load is also 1 cycle.
- Reset asserted mid-count returns everything to reset values immediately.

Optional Feature:
- Macro: RGGEN_COUNTER_SNAPSHOT_EN.
- When defined:
  - Adds input i_snapshot (1 bit) and a CHANNELS*WIDTH shadow register.
  - On i_snapshot=1, shadow <= current counter values (all channels, same edge).
  - o_sw_read_data returns the shadow; read-clear still clears the live counters.
- When undefined: no port, no shadow; read data is the live value.

Test Plan:
- CHANNELS=2, WIDTH=8, SATURATE=1: ch0 up_step=4 for 70 cycles -> o_value ch0 reaches 255 and holds; o_overflow[0]=1 from cycle 64; ch1 stays 0.
- SATURATE=0, ch0=254, up_step=3 -> next value 1, o_overflow[0]=1; software write 0x10 full mask -> value 0x10, o_overflow[0]=0.
- READ_CLEAR=1, ch0=37, read with up_step=2 in the same cycle -> o_sw_read_data=37, next value 2.
- Threshold=100, ch0=98, up_step=5 -> o_threshold_hit[0] pulses once; further counting gives no pulse; down to 90 then up past 100 -> second pulse.
- Same cycle i_hw_clear[0]=1 and software write 0x55 -> value 0 (hw_clear priority); partial mask 0x0F write of 0xAA over 0x33 -> 0x3A.
- Snapshot build: ch0=12, i_snapshot=1, count to 20, read -> 12; assert reset mid-count -> all outputs 0 / INITIAL_VALUE.
